dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-ported 32-word data memory.
- Port 0 is the core load/store path; port 1 is a secondary master (debug loader or DMA).
- Accepts one request per arbitration, drives the memory address/write-data/write-enable for exactly one cycle, and returns registered read data with a valid pulse.
- Round-robin fairness; out-of-range addresses are flagged and never written.

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin two-port arbiter/sequencer in front of a
//            single-ported data memory. One accepted request per arbitration,
//            one-cycle memory access, registered read data with valid pulse.
//            Out-of-range addresses are flagged and never written.
// Options  : DMEM_ARB_STATS_EN - build the saturating per-port acceptance
//            counters (otherwise p0_cnt/p1_cnt are tied to zero).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   // port 0 (core load/store)
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,
   // port 1 (debug loader / DMA)
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   // memory side
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rd,
   // status
   output logic              busy,
   output logic [15:0]       p0_cnt,
   output logic [15:0]       p1_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   // Full-width bound so large addresses never alias into the array.
   localparam logic [ADDR_W-1:0] C_DEPTH = ADDR_W'(DEPTH);

   state_t              state_q;
   logic                last_q;      // id of the most recent winner
   logic                win_q;       // id of the port being served
   logic                we_q;
   logic                in_range_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                p0_rvalid_q, p1_rvalid_q;
   logic [DATA_W-1:0]   p0_rdata_q, p1_rdata_q;
   logic                p0_err_q, p1_err_q;

   logic                arb_open;
   logic                accept;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W-1:0]   resp_data;

   // Arbitration: a lone requester wins, a tie goes to the port that did not win last.
   assign arb_open  = (state_q == ST_IDLE) && !rst;
   assign p0_gnt    = arb_open && p0_req && (!p1_req || last_q);
   assign p1_gnt    = arb_open && p1_req && (!p0_req || !last_q);
   assign accept    = p0_gnt || p1_gnt;
   assign sel_we    = p1_gnt ? p1_we    : p0_we;
   assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
   assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;

   // Memory interface is only driven during the single access cycle.
   assign busy      = (state_q == ST_ACCESS);
   assign mem_a     = busy ? addr_q  : '0;
   assign mem_wd    = busy ? wdata_q : '0;
   assign mem_we    = busy && we_q && in_range_q && !rst;
   assign resp_data = (!we_q && in_range_q) ? mem_rd : '0;

   assign p0_rvalid = p0_rvalid_q;
   assign p1_rvalid = p1_rvalid_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;
   assign p0_err    = p0_err_q;
   assign p1_err    = p1_err_q;

   // Sequencer FSM: latch the winner in IDLE, access memory and capture the response in ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         win_q       <= 1'b0;
         we_q        <= 1'b0;
         in_range_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
         p0_err_q    <= 1'b0;
         p1_err_q    <= 1'b0;
      end else begin
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  win_q      <= p1_gnt;
                  last_q     <= p1_gnt;
                  we_q       <= sel_we;
                  addr_q     <= sel_addr;
                  wdata_q    <= sel_wdata;
                  in_range_q <= (sel_addr < C_DEPTH);
                  state_q    <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               state_q <= ST_IDLE;
               if (win_q) begin
                  p1_rvalid_q <= 1'b1;
                  p1_rdata_q  <= resp_data;
                  p1_err_q    <= !in_range_q;
               end else begin
                  p0_rvalid_q <= 1'b1;
                  p0_rdata_q  <= resp_data;
                  p0_err_q    <= !in_range_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] p0_cnt_q, p1_cnt_q;
   logic [15:0] p0_cnt_d, p1_cnt_d;

   assign p0_cnt_d = (p0_gnt && (p0_cnt_q != 16'hFFFF)) ? p0_cnt_q + 16'd1 : p0_cnt_q;
   assign p1_cnt_d = (p1_gnt && (p1_cnt_q != 16'hFFFF)) ? p1_cnt_q + 16'd1 : p1_cnt_q;

   // Saturating acceptance counters, one per port.
   always_ff @(posedge clk) begin
      if (rst) begin
         p0_cnt_q <= '0;
         p1_cnt_q <= '0;
      end else begin
         p0_cnt_q <= p0_cnt_d;
         p1_cnt_q <= p1_cnt_d;
      end
   end

   assign p0_cnt = p0_cnt_q;
   assign p1_cnt = p1_cnt_q;
`else
   assign p0_cnt = '0;
   assign p1_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A transaction-level model
//            (pending access, pending response, golden memory) predicts every
//            output each cycle; directed scenarios add literal expectations,
//            then a long randomized phase with sporadic resets follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  rq;
   logic [1:0]  wq;
   logic [31:0] ad [2];
   logic [31:0] wd [2];

   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic        mem_we, busy;
   logic [15:0] p0_cnt, p1_cnt;

   // memory environment (owned by the stimulus process)
   logic [31:0] tbmem [32];

   // behavioural model
   logic [31:0] gmem [32];
   logic        mvalid;
   logic        m_busy;
   int          m_port;
   logic        m_we;
   logic [31:0] m_addr, m_wdata;
   int          m_last;
   logic        m_pend;
   int          m_pport;
   logic [31:0] m_rdata [2];
   logic        m_err [2];
   int          m_cnt [2];
   logic [1:0]  m_acc;

   int checks;
   int errors;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .p0_req    (rq[0]),
      .p0_we     (wq[0]),
      .p0_addr   (ad[0]),
      .p0_wdata  (wd[0]),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p0_err    (p0_err),
      .p1_req    (rq[1]),
      .p1_we     (wq[1]),
      .p1_addr   (ad[1]),
      .p1_wdata  (wd[1]),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .p1_err    (p1_err),
      .mem_a     (mem_a),
      .mem_wd    (mem_wd),
      .mem_we    (mem_we),
      .mem_rd    (mem_rd),
      .busy      (busy),
      .p0_cnt    (p0_cnt),
      .p1_cnt    (p1_cnt)
   );

   // out-of-range reads return junk so a missing suppression is visible
   assign mem_rd = (mem_a < 32'd32) ? tbmem[mem_a[4:0]] : (32'hBAD0_0000 ^ mem_a);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_port(input int p, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
      rq[p] = r;
      wq[p] = w;
      ad[p] = a;
      wd[p] = d;
   endtask

   // One clock cycle: compare outputs against the model, advance the model,
   // cross the edge, and commit any memory write the DUT issued.
   task automatic step();
      logic [1:0]  eg;
      logic        inr;
      logic        do_w;
      logic [31:0] wa, wv;
      int          w;
      #1;
      eg[0] = !m_busy && !rst && rq[0] && (!rq[1] || m_last != 0);
      eg[1] = !m_busy && !rst && rq[1] && (!rq[0] || m_last != 1);
      if (mvalid) begin
         chk("p0_gnt",    {31'b0, p0_gnt},    {31'b0, eg[0]});
         chk("p1_gnt",    {31'b0, p1_gnt},    {31'b0, eg[1]});
         chk("busy",      {31'b0, busy},      {31'b0, m_busy});
         chk("mem_a",     mem_a,  m_busy ? m_addr  : 32'd0);
         chk("mem_wd",    mem_wd, m_busy ? m_wdata : 32'd0);
         chk("mem_we",    {31'b0, mem_we},
             {31'b0, m_busy && m_we && (m_addr < 32'd32) && !rst});
         chk("p0_rvalid", {31'b0, p0_rvalid}, {31'b0, m_pend && m_pport == 0});
         chk("p1_rvalid", {31'b0, p1_rvalid}, {31'b0, m_pend && m_pport == 1});
         chk("p0_rdata",  p0_rdata, m_rdata[0]);
         chk("p1_rdata",  p1_rdata, m_rdata[1]);
         chk("p0_err",    {31'b0, p0_err}, {31'b0, m_err[0]});
         chk("p1_err",    {31'b0, p1_err}, {31'b0, m_err[1]});
`ifdef DMEM_ARB_STATS_EN
         chk("p0_cnt",    {16'b0, p0_cnt}, 32'(m_cnt[0]));
         chk("p1_cnt",    {16'b0, p1_cnt}, 32'(m_cnt[1]));
`else
         chk("p0_cnt",    {16'b0, p0_cnt}, 32'd0);
         chk("p1_cnt",    {16'b0, p1_cnt}, 32'd0);
`endif
      end
      do_w = mem_we;
      wa   = mem_a;
      wv   = mem_wd;
      m_acc = rst ? 2'b00 : eg;
      if (rst) begin
         mvalid = 1'b1;
         m_busy = 1'b0;
         m_last = 1;
         m_pend = 1'b0;
         for (int p = 0; p < 2; p++) begin
            m_rdata[p] = 32'd0;
            m_err[p]   = 1'b0;
            m_cnt[p]   = 0;
         end
      end else begin
         m_pend  = m_busy;
         m_pport = m_port;
         if (m_busy) begin
            inr = (m_addr < 32'd32);
            m_rdata[m_port] = (!m_we && inr) ? gmem[m_addr[4:0]] : 32'd0;
            m_err[m_port]   = !inr;
            if (m_we && inr) gmem[m_addr[4:0]] = m_wdata;
         end
         if (eg != 2'b00) begin
            w       = eg[0] ? 0 : 1;
            m_busy  = 1'b1;
            m_port  = w;
            m_we    = wq[w];
            m_addr  = ad[w];
            m_wdata = wd[w];
            m_last  = w;
            if (m_cnt[w] < 65535) m_cnt[w]++;
         end else begin
            m_busy = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (do_w) tbmem[wa[4:0]] = wv;
   endtask

   initial begin
      int order[$];
      int r;
      checks = 0;
      errors = 0;
      mvalid = 1'b0;
      m_busy = 1'b0;
      m_pend = 1'b0;
      m_last = 1;
      m_port = 0;
      m_pport = 0;
      m_acc  = 2'b00;
      rst = 1'b1;
      rq  = 2'b00;
      wq  = 2'b00;
      for (int p = 0; p < 2; p++) begin
         ad[p] = 32'd0; wd[p] = 32'd0; m_rdata[p] = 32'd0; m_err[p] = 1'b0; m_cnt[p] = 0;
      end
      for (int i = 0; i < 32; i++) gmem[i] = $urandom;
      gmem[0] = 32'h0000_A5A5;
      gmem[2] = 32'h2222_0002;
      gmem[9] = 32'h9999_0009;
      for (int i = 0; i < 32; i++) tbmem[i] = gmem[i];

      @(posedge clk);
      #1;
      step();
      step();
      rst = 1'b0;

      // reset state
      #1;
      chk("rst_busy",     {31'b0, busy},      32'd0);
      chk("rst_p0_rdata", p0_rdata,           32'd0);
      chk("rst_p1_err",   {31'b0, p1_err},    32'd0);
      chk("rst_mem_we",   {31'b0, mem_we},    32'd0);

      // p0 write 5 then read back
      set_port(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
      #1 chk("t1_p0_gnt", {31'b0, p0_gnt}, 32'd1);
      step();
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("t1_mem_we", {31'b0, mem_we}, 32'd1);
      chk("t1_mem_a",  mem_a, 32'd5);
      step();
      set_port(0, 1'b1, 1'b0, 32'd5, 32'd0);
      #1;
      chk("t1_p0_rvalid", {31'b0, p0_rvalid}, 32'd1);
      chk("t1_p0_err",    {31'b0, p0_err},    32'd0);
      chk("t1_p0_gnt2",   {31'b0, p0_gnt},    32'd1);
      step();
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      #1;
      chk("t1_rd_rvalid", {31'b0, p0_rvalid}, 32'd1);
      chk("t1_rd_rdata",  p0_rdata, 32'hDEAD_BEEF);
      step();

      // simultaneous reads after reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_port(0, 1'b1, 1'b0, 32'd1, 32'd0);
      set_port(1, 1'b1, 1'b0, 32'd2, 32'd0);
      #1;
      chk("t2_p0_gnt", {31'b0, p0_gnt}, 32'd1);
      chk("t2_p1_gnt", {31'b0, p1_gnt}, 32'd0);
      step();
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("t2_busy",     {31'b0, busy},   32'd1);
      chk("t2_p1_wait",  {31'b0, p1_gnt}, 32'd0);
      step();
      #1;
      chk("t2_p0_rvalid", {31'b0, p0_rvalid}, 32'd1);
      chk("t2_p1_gnt2",   {31'b0, p1_gnt},    32'd1);
      step();
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      #1 chk("t2_p1_norv", {31'b0, p1_rvalid}, 32'd0);
      step();
      #1;
      chk("t2_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
      chk("t2_p1_rdata",  p1_rdata, 32'h2222_0002);
      step();

      // continuous contention: strict alternation
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_port(0, 1'b1, 1'b0, 32'd3, 32'd0);
      set_port(1, 1'b1, 1'b0, 32'd2, 32'd0);
      for (int c = 0; c < 12; c++) begin
         if (c == 11) begin
            set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
            set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
         end
         #1;
         if (p0_gnt) order.push_back(0);
         if (p1_gnt) order.push_back(1);
         step();
      end
      chk("t3_ngrants", 32'(order.size()), 32'd6);
      for (int i = 0; i < order.size(); i++) chk("t3_order", 32'(order[i]), 32'(i % 2));
      step();
      step();
`ifdef DMEM_ARB_STATS_EN
      chk("t3_p0_cnt", {16'b0, p0_cnt}, 32'd3);
      chk("t3_p1_cnt", {16'b0, p1_cnt}, 32'd3);
`else
      chk("t3_p0_cnt", {16'b0, p0_cnt}, 32'd0);
      chk("t3_p1_cnt", {16'b0, p1_cnt}, 32'd0);
`endif

      // out-of-range write on p1
      set_port(1, 1'b1, 1'b1, 32'd32, 32'd7);
      #1 chk("t4_p1_gnt", {31'b0, p1_gnt}, 32'd1);
      step();
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("t4_mem_we", {31'b0, mem_we}, 32'd0);
      chk("t4_busy",   {31'b0, busy},   32'd1);
      step();
      #1;
      chk("t4_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
      chk("t4_p1_err",    {31'b0, p1_err},    32'd1);
      chk("t4_p1_rdata",  p1_rdata,           32'd0);
      step();
      chk("t4_word0", tbmem[0], 32'h0000_A5A5);

      // reset during ACCESS
      set_port(0, 1'b1, 1'b1, 32'd9, 32'h1234_5678);
      #1 chk("t5_p0_gnt", {31'b0, p0_gnt}, 32'd1);
      step();
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      rst = 1'b1;
      #1 chk("t5_mem_we", {31'b0, mem_we}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("t5_busy",   {31'b0, busy},      32'd0);
      chk("t5_norv_a", {31'b0, p0_rvalid}, 32'd0);
      step();
      #1 chk("t5_norv_b", {31'b0, p0_rvalid}, 32'd0);
      set_port(0, 1'b1, 1'b0, 32'd4, 32'd0);
      set_port(1, 1'b1, 1'b0, 32'd6, 32'd0);
      #1;
      chk("t5_tie_p0", {31'b0, p0_gnt}, 32'd1);
      chk("t5_tie_p1", {31'b0, p1_gnt}, 32'd0);
      step();
      set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      chk("t5_word9", tbmem[9], 32'h9999_0009);

      // randomized traffic with sporadic resets
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         for (int p = 0; p < 2; p++) begin
            if (rq[p] && m_acc[p]) rq[p] = 1'b0;
            if (!rq[p] && $urandom_range(0, 2) != 0) begin
               r = $urandom_range(0, 9);
               rq[p] = 1'b1;
               wq[p] = 1'($urandom_range(0, 1));
               if (r == 0)      ad[p] = 32'd32 + 32'($urandom_range(0, 31));
               else if (r == 1) ad[p] = $urandom | 32'h8000_0000;
               else             ad[p] = 32'($urandom_range(0, 31));
               wd[p] = $urandom;
            end
         end
         step();
      end
      rst = 1'b0;
      rq  = 2'b00;
      step();
      step();
      step();
      for (int i = 0; i < 32; i++) chk("mem_word", tbmem[i], gmem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
